// File: rtl/cern_io_bank_ctrl.sv
// cern_io_bank_ctrl
//   Controls a bank of NCH 1.2 V CMOS I/O pads and sits between the chip
//   configuration logic and the pad ring.
//   - Per-channel pad configuration is double-buffered. Writes go into a
//     shadow copy, and an apply request commits the shadow copy to the
//     active copy atomically.
//   - Channels whose output enable changes at apply are held in tristate
//     for GUARD cycles before the new configuration lands
//     (break-before-make).
//   - Pad Z inputs are synchronised and deglitched before they reach the core.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous reset, active-low
//   cfg_valid_i  config write request
//   cfg_ready_o  write accepted when valid & ready; high only in IDLE
//   cfg_ch_i     target channel; channels >= NCH are accepted and dropped
//   cfg_data_i   {DS, OUT_EN, UD_B, PEN} for cfg_ch_i
//   cfg_apply_i  single-cycle request to commit shadow -> active
//   filt_len_i   deglitch length (quasi-static)
//   a_core_i     core data toward pads
//   z_pad_i      asynchronous pad Z pins
//   pen_o        pull enable per pad
//   ud_b_o       pull select per pad (0 = pull-up, 1 = pull-down)
//   out_en_o     output enable per pad
//   ds_o         drive-strength select per pad
//   a_o          registered a_core_i
//   z_core_o     filtered pad input
//   z_change_o   one-cycle pulse when z_core_o changes
//
// state  | meaning
// IDLE   | accepting writes and apply requests
// DRAIN  | changing channels are tristated; counting GUARD cycles
// COMMIT | shadow copied into active on exit
module cern_io_bank_ctrl #(
  parameter int NCH    = 8,
  parameter int FILT_W = 3,
  parameter int GUARD  = 2,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [3:0]        cfg_data_i,
  input  logic              cfg_apply_i,
  input  logic [FILT_W-1:0] filt_len_i,
  input  logic [NCH-1:0]    a_core_i,
  input  logic [NCH-1:0]    z_pad_i,
  output logic [NCH-1:0]    pen_o,
  output logic [NCH-1:0]    ud_b_o,
  output logic [NCH-1:0]    out_en_o,
  output logic [NCH-1:0]    ds_o,
  output logic [NCH-1:0]    a_o,
  output logic [NCH-1:0]    z_core_o,
  output logic [NCH-1:0]    z_change_o
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

  state_t state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;

  logic [NCH-1:0] sh_pen_q, sh_ud_q, sh_oe_q, sh_ds_q;
  logic [NCH-1:0] sh_pen_d, sh_ud_d, sh_oe_d, sh_ds_d;
  logic [NCH-1:0] pen_q, ud_q, oe_q, ds_q;
  logic [NCH-1:0] pen_d, ud_d, oe_d, ds_d;
  logic [NCH-1:0] out_en_q, out_en_d;
  logic [NCH-1:0] a_q;

  logic [NCH-1:0]    s1_q, s2_q;
  logic [NCH-1:0]    zc_q, zc_d, zchg_q, zchg_d;
  logic [FILT_W-1:0] cnt_q [NCH];
  logic [FILT_W-1:0] cnt_d [NCH];

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_apply_i) state_d = (GUARD > 0) ? DRAIN : COMMIT;
      DRAIN:   if (guard_q == '0) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready_o = (state_q == IDLE);
  end

  // Shadow writes, guard timer, active commit and output-enable masking
  always_comb begin
    sh_pen_d = sh_pen_q;
    sh_ud_d  = sh_ud_q;
    sh_oe_d  = sh_oe_q;
    sh_ds_d  = sh_ds_q;
    if (cfg_ready_o && cfg_valid_i && ({1'b0, cfg_ch_i} < NCH_L)) begin
      sh_pen_d[cfg_ch_i] = cfg_data_i[0];
      sh_ud_d[cfg_ch_i]  = cfg_data_i[1];
      sh_oe_d[cfg_ch_i]  = cfg_data_i[2];
      sh_ds_d[cfg_ch_i]  = cfg_data_i[3];
    end

    guard_d = guard_q;
    if (state_q == IDLE)                       guard_d = GUARD_LOAD;
    else if (state_q == DRAIN && guard_q != '0) guard_d = guard_q - 1'b1;

    pen_d = pen_q;
    ud_d  = ud_q;
    oe_d  = oe_q;
    ds_d  = ds_q;
    if (state_q == COMMIT) begin
      pen_d = sh_pen_q;
      ud_d  = sh_ud_q;
      oe_d  = sh_oe_q;
      ds_d  = sh_ds_q;
    end

    // Shadow and active are frozen outside IDLE, so the direction-change
    // mask computed here equals the one captured at the apply edge.
    out_en_d = oe_d & ~((oe_q ^ sh_oe_d) & {NCH{state_d != IDLE}});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      guard_q  <= '0;
      sh_pen_q <= '1;
      sh_ud_q  <= '1;
      sh_oe_q  <= '0;
      sh_ds_q  <= '0;
      pen_q    <= '1;
      ud_q     <= '1;
      oe_q     <= '0;
      ds_q     <= '0;
      out_en_q <= '0;
      a_q      <= '0;
    end else begin
      guard_q  <= guard_d;
      sh_pen_q <= sh_pen_d;
      sh_ud_q  <= sh_ud_d;
      sh_oe_q  <= sh_oe_d;
      sh_ds_q  <= sh_ds_d;
      pen_q    <= pen_d;
      ud_q     <= ud_d;
      oe_q     <= oe_d;
      ds_q     <= ds_d;
      out_en_q <= out_en_d;
      a_q      <= a_core_i;
    end
  end

  // Deglitch filter. A count left above filt_len_i by a shrinking length
  // commits on the next compare instead of wrapping.
  always_comb begin
    zc_d   = zc_q;
    zchg_d = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != zc_q[i]) begin
        if (cnt_q[i] >= filt_len_i) begin
          zc_d[i]   = s2_q[i];
          zchg_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= '0;
      s2_q   <= '0;
      zc_q   <= '0;
      zchg_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= z_pad_i;
      s2_q   <= s1_q;
      zc_q   <= zc_d;
      zchg_q <= zchg_d;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pen_o      = pen_q;
  assign ud_b_o     = ud_q;
  assign out_en_o   = out_en_q;
  assign ds_o       = ds_q;
  assign a_o        = a_q;
  assign z_core_o   = zc_q;
  assign z_change_o = zchg_q;

endmodule

// File: tb/tb_cern_io_bank_ctrl.sv
// Directed bench for cern_io_bank_ctrl with NCH=6, FILT_W=3, GUARD=2.
// NCH=6 makes channel 6 representable on the 3-bit channel port.
module tb_cern_io_bank_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       cfg_valid_i, cfg_apply_i;
  logic       cfg_ready_o;
  logic [2:0] cfg_ch_i;
  logic [3:0] cfg_data_i;
  logic [2:0] filt_len_i;
  logic [5:0] a_core_i, z_pad_i;
  logic [5:0] pen_o, ud_b_o, out_en_o, ds_o, a_o, z_core_o, z_change_o;

  int n_chk  = 0;
  int n_fail = 0;

  cern_io_bank_ctrl #(.NCH(6), .FILT_W(3), .GUARD(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_ch_i(cfg_ch_i), .cfg_data_i(cfg_data_i), .cfg_apply_i(cfg_apply_i),
    .filt_len_i(filt_len_i), .a_core_i(a_core_i), .z_pad_i(z_pad_i),
    .pen_o(pen_o), .ud_b_o(ud_b_o), .out_en_o(out_en_o), .ds_o(ds_o),
    .a_o(a_o), .z_core_o(z_core_o), .z_change_o(z_change_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cfgv(input logic [5:0] p, input logic [5:0] u,
                                       input logic [5:0] o, input logic [5:0] d);
    return {8'h00, p, u, o, d};
  endfunction

  function automatic logic [31:0] cur_cfg();
    return {8'h00, pen_o, ud_b_o, out_en_o, ds_o};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [3:0] data);
    cfg_valid_i = 1'b1;
    cfg_ch_i    = ch;
    cfg_data_i  = data;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic apply();
    cfg_apply_i = 1'b1;
    tick();
    cfg_apply_i = 1'b0;
  endtask

  logic seen;

  initial begin
    rst_ni      = 1'b0;
    cfg_valid_i = 1'b0;
    cfg_apply_i = 1'b0;
    cfg_ch_i    = '0;
    cfg_data_i  = '0;
    filt_len_i  = 3'd2;
    a_core_i    = '0;
    z_pad_i     = '0;
    repeat (3) tick();
    rst_ni = 1'b1;

    // reset state
    chk("rst_cfg", cur_cfg(), cfgv(6'h3F, 6'h3F, 6'h00, 6'h00));
    chk("rst_ready", 32'(cfg_ready_o), 32'd1);
    chk("rst_zcore", 32'(z_core_o), 32'd0);
    chk("rst_a", 32'(a_o), 32'd0);

    // ch3 <= DS=1 OE=0 UD_B=0 PEN=1; no effect until apply
    wr(3'd3, 4'b1001);
    chk("wr_noapply", cur_cfg(), cfgv(6'h3F, 6'h3F, 6'h00, 6'h00));
    apply();
    chk("rdy_a1", 32'(cfg_ready_o), 32'd0);
    tick();
    chk("rdy_a2", 32'(cfg_ready_o), 32'd0);
    tick();
    chk("rdy_a3", 32'(cfg_ready_o), 32'd0);
    chk("cfg_hold", cur_cfg(), cfgv(6'h3F, 6'h3F, 6'h00, 6'h00));
    tick();
    chk("rdy_back", 32'(cfg_ready_o), 32'd1);
    chk("cfg_ch3", cur_cfg(), cfgv(6'h3F, 6'b110111, 6'h00, 6'b001000));

    // ch1 output enabled first
    wr(3'd1, 4'b0111);
    apply();
    repeat (3) tick();
    chk("oe_ch1", 32'(out_en_o), 32'h02);

    // ch0 0->1 and ch1 1->0; the ch1 write shares the apply cycle
    wr(3'd0, 4'b0111);
    cfg_valid_i = 1'b1; cfg_ch_i = 3'd1; cfg_data_i = 4'b0011; cfg_apply_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0; cfg_apply_i = 1'b0;
    chk("bbm_a", 32'(out_en_o), 32'h00);
    tick();
    chk("bbm_a1", 32'(out_en_o), 32'h00);
    tick();
    chk("bbm_a2", 32'(out_en_o), 32'h00);
    tick();
    chk("bbm_a3", 32'(out_en_o), 32'h01);

    // apply and write during DRAIN: apply dropped, write stalled then accepted
    apply();
    chk("drain_oe_keep", 32'(out_en_o), 32'h01);
    cfg_apply_i = 1'b1; cfg_valid_i = 1'b1; cfg_ch_i = 3'd2; cfg_data_i = 4'b1111;
    tick();
    cfg_apply_i = 1'b0;
    chk("stall_rdy", 32'(cfg_ready_o), 32'd0);
    tick();
    tick();
    chk("stall_idle", 32'(cfg_ready_o), 32'd1);
    tick();
    cfg_valid_i = 1'b0;
    chk("apply_dropped", 32'(cfg_ready_o), 32'd1);
    chk("cfg_unchanged", cur_cfg(), cfgv(6'h3F, 6'b110111, 6'h01, 6'b001000));
    apply();
    repeat (3) tick();
    chk("cfg_ch2", cur_cfg(), cfgv(6'h3F, 6'b110111, 6'b000101, 6'b001100));

    // out-of-range channel: handshake completes, nothing changes
    cfg_valid_i = 1'b1; cfg_ch_i = 3'd6; cfg_data_i = 4'b1100;
    chk("ch6_ready", 32'(cfg_ready_o), 32'd1);
    tick();
    cfg_valid_i = 1'b0;
    apply();
    repeat (3) tick();
    chk("ch6_drop", cur_cfg(), cfgv(6'h3F, 6'b110111, 6'b000101, 6'b001100));

    // async reset during DRAIN
    wr(3'd4, 4'b1100);
    apply();
    tick();
    chk("pre_rst_rdy", 32'(cfg_ready_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("rst_async_cfg", cur_cfg(), cfgv(6'h3F, 6'h3F, 6'h00, 6'h00));
    chk("rst_async_rdy", 32'(cfg_ready_o), 32'd1);
    tick();
    rst_ni = 1'b1;
    apply();
    repeat (3) tick();
    chk("post_rst_apply", cur_cfg(), cfgv(6'h3F, 6'h3F, 6'h00, 6'h00));

    // A path, 1-cycle latency
    a_core_i = 6'h2A;
    tick();
    chk("a_lat1", 32'(a_o), 32'h2A);
    a_core_i = 6'h15;
    chk("a_hold", 32'(a_o), 32'h2A);
    tick();
    chk("a_lat2", 32'(a_o), 32'h15);

    // FILT_LEN=2: a 2-cycle pulse is suppressed
    z_pad_i = 6'b100000;
    tick();
    tick();
    z_pad_i = '0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | z_core_o[5] | z_change_o[5];
    end
    chk("glitch_supp", 32'(seen), 32'd0);

    // 6-cycle pulse passes: Z_CORE rises 5 edges after the rise
    z_pad_i = 6'b100000;
    repeat (4) tick();
    chk("rise_early", 32'(z_core_o), 32'h00);
    tick();
    chk("rise_zcore", 32'(z_core_o), 32'h20);
    chk("rise_pulse", 32'(z_change_o), 32'h20);
    tick();
    chk("rise_pulse_end", 32'(z_change_o), 32'h00);
    z_pad_i = '0;
    repeat (4) tick();
    chk("fall_early", 32'(z_core_o), 32'h20);
    tick();
    chk("fall_zcore", 32'(z_core_o), 32'h00);
    chk("fall_pulse", 32'(z_change_o), 32'h20);

    // FILT_LEN=0: a single-cycle pulse passes after 3 edges
    filt_len_i = 3'd0;
    z_pad_i = 6'b000001;
    tick();
    z_pad_i = '0;
    tick();
    tick();
    chk("f0_rise", 32'(z_core_o), 32'h01);
    chk("f0_pulse", 32'(z_change_o), 32'h01);
    tick();
    chk("f0_fall", 32'(z_core_o), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
